vram_dma_m: RTL and testbench
=============================

Name: vram_dma_m

Overview:
Single-clock DMA engine and VRAM bus arbiter on the cpu_clk side of the GPU. The CPU writes a source page number, and the block copies XFER_LEN bytes from system memory into object memory (OBM) through the GPU VRAM write port. While it copies, the block owns the VRAM write port and stalls the CPU. When idle, CPU VRAM accesses pass through unchanged.

Parameters:
XFER_LEN, 256, bytes per transfer; legal range 1..256; 256 fills the OBM for 64 objects at 4 bytes each.
DEST_BASE, 0, first VRAM address written (within the OBM window); width `VRAM_ADDR_WIDTH.

Ports:
cpu_clk  in  1  sole clock; all state on its rising edge
rst  in  1  asynchronous, active-high reset
cpu_data_in  in  8  CPU write data
cpu_vram_address  in  `VRAM_ADDR_WIDTH  CPU VRAM address
cpu_write_enable  in  1  CPU write strobe
cpu_SELECT_obm  in  1  CPU targets the OBM
SELECT_dma_start  in  1  start register decode; a write starts a transfer from page cpu_data_in
SELECT_clr_dma_irq  in  1  a write clears done_irq
writable  in  1  GPU vblank window flag
mem_address  out  16  system memory read address
mem_read  out  1  read strobe; mem_data is valid the next cycle
mem_data  in  8  system memory read data
vram_address  out  `VRAM_ADDR_WIDTH  arbitrated VRAM address
vram_data  out  8  arbitrated VRAM write data
vram_write_enable  out  1  arbitrated write strobe
vram_SELECT_obm  out  1  arbitrated OBM select
cpu_rdy  out  1  low means the CPU must stall
busy  out  1  transfer in progress
done_irq  out  1  sticky completion interrupt

Behaviour:
- Reset values: state IDLE; mem_read=0; mem_address=0; cpu_rdy=1; busy=0; done_irq=0. Counter and page register are 0. Arbiter is in passthrough.
- Start condition: cpu_write_enable && SELECT_dma_start in IDLE. Latch page=cpu_data_in, set i=0, go to ARM.
- A start write while busy is ignored; page is unchanged.
- States: IDLE -> ARM -> XFER -> FLUSH -> IDLE.
- ARM: busy=1 and cpu_rdy=0 from the cycle after the start write. Moves to XFER on the next cycle (with the optional feature, when writable=1).
- XFER is pipelined at one byte per cycle:
  - Each cycle drives mem_read=1 and mem_address={page,8'h00}+i.
  - In the same cycle it writes byte i-1, captured from mem_data, to DEST_BASE+i-1, except on the first XFER cycle.
  - i is XFER_LEN-bit-safe; the source never crosses the page because XFER_LEN<=256.
- FLUSH: writes the final byte; no read is issued. Then the block returns to IDLE, busy=0, cpu_rdy=1, and done_irq is set.
- Total latency: XFER_LEN+2 cycles from the start write to busy falling.
- Arbitration:
  - When busy=0, the vram_* outputs equal the cpu_* inputs combinationally.
  - When busy=1, the DMA drives vram_* outputs. vram_SELECT_obm=1 only on DMA write cycles.
  - CPU VRAM writes during busy are dropped; cpu_rdy=0 makes the CPU hold them.
- done_irq:
  - Set in the FLUSH->IDLE cycle.
  - Cleared by cpu_write_enable && SELECT_clr_dma_irq.
  - If set and clear occur in the same cycle, set wins.
- VRAM address arithmetic wraps modulo 2^`VRAM_ADDR_WIDTH.
- Reset mid-transfer aborts at once: the partially written OBM contents stand, no irq is raised, and passthrough resumes.

Optional Feature:
VRAM_DMA_WAIT_VBLANK_EN.
- Defined:
  - ARM waits for writable=1.
  - If writable falls during XFER, the block enters PAUSE. The byte already read is still written in the next cycle, then i is held and no reads are issued.
  - The block resumes XFER (with no write on the resume cycle) when writable=1.
  - busy and cpu_rdy stay asserted throughout.
- Undefined: writable is ignored; ARM always lasts one cycle and PAUSE does not exist.

Decomposition:
- Package vram_dma_pkg holds:
  - the state enum (IDLE, ARM, XFER, PAUSE, FLUSH);
  - the localparam for counter width, $clog2(XFER_LEN+1);
  - the start/clear register offsets.
- Sub-module vram_dma_arbiter_m is the natural split: a pure 2:1 mux of the vram_* outputs, selected by busy and the DMA write strobe.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: CPU writes 0x5A to OBM address 3 -> vram_* mirrors it in the same cycle; busy=0, cpu_rdy=1.
- Start page 0x02 with XFER_LEN=256 and memory[0x0200+k]=k^0xA5 -> 256 OBM writes to DEST_BASE+k with data k^0xA5; busy high for 258 cycles; done_irq=1 afterwards.
- Start write during busy with data 0x07 -> ignored; all reads stay in page 0x02.
- done_irq set coincides with a clear write -> done_irq=1; a later clear write -> 0.
- Reset asserted at byte 100 -> busy=0, cpu_rdy=1, done_irq=0 within the same cycle; OBM bytes 0..98 are written; no further writes.
- With VRAM_DMA_WAIT_VBLANK_EN: start with writable=0 -> no reads until writable rises. Dropping writable at byte 50 -> byte 49 is written, then a stall. Resuming -> bytes 50..255 are correct and the final data is identical to the un-paused run.

Source files
------------

// File: rtl/vram_dma_pkg.sv
// Shared types and constants for the VRAM DMA engine.
// Optional feature macro: VRAM_DMA_WAIT_VBLANK_EN (see vram_dma_m.sv).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

package vram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_XFER  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FLUSH = 3'd4
  } dma_state_e;

  // Largest legal transfer; the byte counter must be able to hold this value.
  localparam int XFER_LEN_MAX = 256;
  localparam int CNT_W        = $clog2(XFER_LEN_MAX + 1);

  // CPU register offsets decoded upstream into SELECT_dma_start / SELECT_clr_dma_irq.
  localparam logic [7:0] REG_DMA_START   = 8'h00;
  localparam logic [7:0] REG_CLR_DMA_IRQ = 8'h01;

endpackage

// File: rtl/vram_dma_if.sv
// Bus bundle between the CPU/system side and the VRAM DMA engine.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

// Handshake rules: mem_read is a one-cycle strobe and mem_data holds the byte at
// mem_address in the following cycle; cpu_rdy low means the CPU must hold its
// current access (VRAM writes presented while busy are dropped); vram_write_enable
// is a single-cycle write strobe qualified by vram_address/vram_data/vram_SELECT_obm.
interface vram_dma_if;
  logic [7:0]                  cpu_data_in;
  logic [`VRAM_ADDR_WIDTH-1:0] cpu_vram_address;
  logic                        cpu_write_enable;
  logic                        cpu_SELECT_obm;
  logic                        SELECT_dma_start;
  logic                        SELECT_clr_dma_irq;
  logic                        writable;
  logic [15:0]                 mem_address;
  logic                        mem_read;
  logic [7:0]                  mem_data;
  logic [`VRAM_ADDR_WIDTH-1:0] vram_address;
  logic [7:0]                  vram_data;
  logic                        vram_write_enable;
  logic                        vram_SELECT_obm;
  logic                        cpu_rdy;
  logic                        busy;
  logic                        done_irq;

  modport master (
    output cpu_data_in, cpu_vram_address, cpu_write_enable, cpu_SELECT_obm,
           SELECT_dma_start, SELECT_clr_dma_irq, writable, mem_data,
    input  mem_address, mem_read, vram_address, vram_data, vram_write_enable,
           vram_SELECT_obm, cpu_rdy, busy, done_irq
  );

  modport slave (
    input  cpu_data_in, cpu_vram_address, cpu_write_enable, cpu_SELECT_obm,
           SELECT_dma_start, SELECT_clr_dma_irq, writable, mem_data,
    output mem_address, mem_read, vram_address, vram_data, vram_write_enable,
           vram_SELECT_obm, cpu_rdy, busy, done_irq
  );
endinterface

// File: rtl/vram_dma_arbiter_m.sv
// 2:1 VRAM write-port mux: CPU passthrough when idle, DMA owns the port when busy.
module vram_dma_arbiter_m #(
  parameter int AW = 10
) (
  input  logic          busy,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_data,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  input  logic          cpu_we,
  input  logic          cpu_sel,
  output logic [AW-1:0] vram_addr,
  output logic [7:0]    vram_data,
  output logic          vram_we,
  output logic          vram_sel
);

  // Select the port owner; CPU writes during a transfer never reach VRAM.
  always_comb begin
    vram_addr = cpu_addr;
    vram_data = cpu_data;
    vram_we   = cpu_we;
    vram_sel  = cpu_sel;
    if (busy) begin
      vram_addr = dma_addr;
      vram_data = dma_data;
      vram_we   = dma_we;
      vram_sel  = dma_we;
    end
  end

endmodule

// File: rtl/vram_dma_m.sv
// VRAM DMA engine: copies XFER_LEN bytes of a system-memory page into the OBM.
// Optional feature macro: VRAM_DMA_WAIT_VBLANK_EN (gate copying on writable).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module vram_dma_m
  import vram_dma_pkg::*;
#(
  parameter int                          XFER_LEN  = 256,
  parameter logic [`VRAM_ADDR_WIDTH-1:0] DEST_BASE = '0
) (
  input  logic       cpu_clk,
  input  logic       rst,
  vram_dma_if.slave  bus,
  output dma_state_e dbg_state
);

  localparam int AW = `VRAM_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(XFER_LEN - 1);

  dma_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       page_q, page_d;
  logic             rd_valid_q, rd_valid_d;  // mem_data holds a byte to write this cycle
  logic             done_irq_q, done_irq_d;
  logic             mem_read, dma_we, busy, go;
  logic [AW-1:0]    dma_addr;
  logic             start_wr, clr_wr;

  assign start_wr = bus.cpu_write_enable && bus.SELECT_dma_start;
  assign clr_wr   = bus.cpu_write_enable && bus.SELECT_clr_dma_irq;

`ifdef VRAM_DMA_WAIT_VBLANK_EN
  assign go = bus.writable;
`else
  logic unused_writable;
  assign unused_writable = bus.writable;
  assign go = 1'b1;
`endif

  // Next-state, counter and strobe decode for the copy sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_d     = page_q;
    rd_valid_d = 1'b0;
    mem_read   = 1'b0;
    dma_we     = 1'b0;
    done_irq_d = done_irq_q;
    if (clr_wr) done_irq_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          page_d  = bus.cpu_data_in;
          cnt_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (go) state_d = ST_XFER;
      end
      ST_XFER: begin
        // Write the byte fetched last cycle while fetching the next one.
        dma_we = rd_valid_q;
        if (go) begin
          mem_read   = 1'b1;
          rd_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_FLUSH;
        end
`ifdef VRAM_DMA_WAIT_VBLANK_EN
        else begin
          state_d = ST_PAUSE;
        end
`endif
      end
`ifdef VRAM_DMA_WAIT_VBLANK_EN
      ST_PAUSE: begin
        if (go) state_d = ST_XFER;
      end
`endif
      ST_FLUSH: begin
        dma_we     = 1'b1;
        done_irq_d = 1'b1;  // set beats a coincident clear
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, page and irq registers; reset aborts any transfer at once.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      page_q     <= '0;
      rd_valid_q <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      rd_valid_q <= rd_valid_d;
      done_irq_q <= done_irq_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign dma_addr = DEST_BASE + AW'(cnt_q - CNT_W'(1));

  assign bus.busy        = busy;
  assign bus.cpu_rdy     = !busy;
  assign bus.done_irq    = done_irq_q;
  assign bus.mem_read    = mem_read;
  assign bus.mem_address = {page_q, cnt_q[7:0]};
  assign dbg_state       = state_q;

  vram_dma_arbiter_m #(.AW(AW)) u_arb (
    .busy      (busy),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_data  (bus.mem_data),
    .cpu_addr  (bus.cpu_vram_address),
    .cpu_data  (bus.cpu_data_in),
    .cpu_we    (bus.cpu_write_enable),
    .cpu_sel   (bus.cpu_SELECT_obm),
    .vram_addr (bus.vram_address),
    .vram_data (bus.vram_data),
    .vram_we   (bus.vram_write_enable),
    .vram_sel  (bus.vram_SELECT_obm)
  );

endmodule

// File: tb/tb_vram_dma_m.sv
// Bench for vram_dma_m: passthrough vectors, full page copies, irq set/clear race,
// reset abort, and (with VRAM_DMA_WAIT_VBLANK_EN) vblank wait/pause behaviour.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module tb_vram_dma_m;
  import vram_dma_pkg::*;

  localparam int AW = `VRAM_ADDR_WIDTH;
  localparam int N  = 256;
  localparam logic [AW-1:0] DBASE = AW'(32'h380);  // makes destination addresses wrap

  logic       cpu_clk = 1'b0;
  logic       rst;
  dma_state_e dbg_state;
  int         checks = 0;
  int         errors = 0;

  vram_dma_if bus();

  vram_dma_m #(.XFER_LEN(N), .DEST_BASE(DBASE)) dut (
    .cpu_clk   (cpu_clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- system memory model: data one cycle after the read strobe
  logic [7:0] sysmem [0:65535];
  always @(posedge cpu_clk) if (bus.mem_read) bus.mem_data <= sysmem[bus.mem_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: expected OBM writes in order ----------------
  logic [AW+7:0] exp_q[$];
  bit            sb_en = 1'b0;
  logic [7:0]    exp_page;

  always @(negedge cpu_clk) begin
    if (sb_en && bus.mem_read) check("read_page", bus.mem_address[15:8], exp_page);
    if (sb_en && bus.vram_write_enable && bus.vram_SELECT_obm) begin
      if (exp_q.size() == 0) check("extra_write", {bus.vram_address, bus.vram_data}, '1);
      else check("obm_write", {bus.vram_address, bus.vram_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_reg_write(input bit start, input bit clr, input logic [7:0] d);
    @(posedge cpu_clk); #1;
    bus.cpu_data_in = d; bus.cpu_write_enable = 1'b1;
    bus.SELECT_dma_start = start; bus.SELECT_clr_dma_irq = clr;
    @(posedge cpu_clk); #1;
    bus.cpu_write_enable = 1'b0; bus.SELECT_dma_start = 1'b0; bus.SELECT_clr_dma_irq = 1'b0;
  endtask

  // Fill the source page and queue the writes the spec says must appear.
  task automatic load_page(input logic [7:0] page, input bit pattern, input int nexp);
    logic [AW-1:0] a;
    logic [7:0]    kb;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      kb = k[7:0];
      sysmem[{page, kb}] = pattern ? (kb ^ 8'hA5) : 8'($urandom_range(0, 255));
      a = DBASE + AW'(k);
      if (k < nexp) exp_q.push_back({a, sysmem[{page, kb}]});
    end
    exp_page = page;
  endtask

  task automatic run_xfer(input logic [7:0] page, input bit pattern, input int drop_at,
                          input int hold, input int pre_hold, input bit clr_at_end,
                          input bit inject_start);
    int cyc = 0;
    int lo_left = pre_hold;
    bit dropped = 1'b0;
    load_page(page, pattern, N);
    sb_en = 1'b1;
    bus.writable = (pre_hold > 0) ? 1'b0 : 1'b1;
    cpu_reg_write(1'b1, 1'b0, page);
    check("busy_after_start", bus.busy, 1'b1);
    check("rdy_after_start", bus.cpu_rdy, 1'b0);
    while (bus.busy && cyc < 2000) begin
      cyc++;
      bus.writable = (lo_left > 0) ? 1'b0 : 1'b1;
      if (inject_start && cyc == 20) begin
        bus.cpu_data_in = 8'h07; bus.cpu_write_enable = 1'b1; bus.SELECT_dma_start = 1'b1;
        bus.cpu_SELECT_obm = 1'b1; bus.cpu_vram_address = AW'($urandom_range(0, 1023));
      end
      if (clr_at_end && cyc == N + 2) begin
        bus.cpu_write_enable = 1'b1; bus.SELECT_clr_dma_irq = 1'b1;
      end
      #1;
      if (drop_at >= 0 && !dropped && lo_left == 0 && bus.mem_read &&
          bus.mem_address[7:0] == 8'(drop_at)) begin
        dropped = 1'b1; lo_left = hold; bus.writable = 1'b0; #1;
      end
      if (lo_left > 0) begin
`ifdef VRAM_DMA_WAIT_VBLANK_EN
        check("no_read_while_blocked", bus.mem_read, 1'b0);
        check("busy_while_blocked", bus.busy, 1'b1);
`endif
        lo_left--;
      end
      check("rdy_low_while_busy", bus.cpu_rdy, 1'b0);
      @(posedge cpu_clk); #1;
      bus.cpu_write_enable = 1'b0; bus.SELECT_dma_start = 1'b0;
      bus.SELECT_clr_dma_irq = 1'b0; bus.cpu_SELECT_obm = 1'b0;
    end
    bus.writable = 1'b1;
    check("xfer_completes", bus.busy, 1'b0);
`ifndef VRAM_DMA_WAIT_VBLANK_EN
    check("busy_cycles", cyc, N + 2);
`endif
    check("writes_left", exp_q.size(), 0);
    check("rdy_after_done", bus.cpu_rdy, 1'b1);
    check("irq_after_done", bus.done_irq, 1'b1);
    sb_en = 1'b0;
  endtask

  // ---------------- passthrough vectors ----------------
  typedef struct {
    logic [AW-1:0] addr; logic [7:0] data; logic we; logic sel;
    logic [AW-1:0] e_addr; logic [7:0] e_data; logic e_we; logic e_sel;
  } vec_t;
  vec_t tbl[5];

  task automatic apply_vec(input vec_t v);
    bus.cpu_vram_address = v.addr; bus.cpu_data_in = v.data;
    bus.cpu_write_enable = v.we;   bus.cpu_SELECT_obm = v.sel;
    #1;
    check("pt_addr", bus.vram_address, v.e_addr);
    check("pt_data", bus.vram_data, v.e_data);
    check("pt_we", bus.vram_write_enable, v.e_we);
    check("pt_sel", bus.vram_SELECT_obm, v.e_sel);
    check("pt_busy", bus.busy, 1'b0);
    check("pt_rdy", bus.cpu_rdy, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    vec_t rv;
    bus.cpu_data_in = '0; bus.cpu_vram_address = '0; bus.cpu_write_enable = 1'b0;
    bus.cpu_SELECT_obm = 1'b0; bus.SELECT_dma_start = 1'b0; bus.SELECT_clr_dma_irq = 1'b0;
    bus.writable = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rdy", bus.cpu_rdy, 1'b1);
    check("rst_irq", bus.done_irq, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_addr", bus.mem_address, 16'h0000);
    rst = 1'b0;

    tbl[0] = '{AW'(3),    8'h5A, 1'b1, 1'b1, AW'(3),    8'h5A, 1'b1, 1'b1};
    tbl[1] = '{AW'(1023), 8'hFF, 1'b1, 1'b0, AW'(1023), 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{AW'(0),    8'h00, 1'b0, 1'b1, AW'(0),    8'h00, 1'b0, 1'b1};
    tbl[3] = '{AW'(512),  8'h3C, 1'b0, 1'b0, AW'(512),  8'h3C, 1'b0, 1'b0};
    tbl[4] = '{AW'(85),   8'hC3, 1'b1, 1'b1, AW'(85),   8'hC3, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
    for (int i = 0; i < 12; i++) begin
      rv.addr = AW'($urandom_range(0, 1023)); rv.data = 8'($urandom_range(0, 255));
      rv.we = 1'($urandom_range(0, 1)); rv.sel = 1'($urandom_range(0, 1));
      rv.e_addr = rv.addr; rv.e_data = rv.data; rv.e_we = rv.we; rv.e_sel = rv.sel;
      apply_vec(rv);
    end
    bus.cpu_write_enable = 1'b0; bus.cpu_SELECT_obm = 1'b0;

    // Page 0x02 pattern copy, ignored restart to page 0x07, writable dip at byte 50.
    run_xfer(8'h02, 1'b1, 50, 6, 0, 1'b0, 1'b1);
    cpu_reg_write(1'b0, 1'b1, 8'h00);
    check("irq_cleared", bus.done_irq, 1'b0);

    // Random page; clear write lands in the FLUSH cycle so set must win.
    run_xfer(8'($urandom_range(3, 255)), 1'b0, -1, 0, 0, 1'b1, 1'b0);
    check("irq_set_wins", bus.done_irq, 1'b1);

    // Reset while reading byte 100: bytes 0..98 stand, nothing after.
    load_page(8'h11, 1'b0, 99);
    sb_en = 1'b1;
    cpu_reg_write(1'b1, 1'b0, 8'h11);
    n = 0;
    while (!(bus.mem_read && bus.mem_address[7:0] == 8'd100) && n < 1000) begin
      @(posedge cpu_clk); #1; n++;
    end
    check("abort_reached_byte100", (n < 1000), 1'b1);
    rst = 1'b1; #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_rdy", bus.cpu_rdy, 1'b1);
    check("abort_irq", bus.done_irq, 1'b0);
    check("abort_mem_read", bus.mem_read, 1'b0);
    repeat (2) @(posedge cpu_clk);
    #1; rst = 1'b0;
    repeat (4) @(posedge cpu_clk);
    #1;
    check("abort_writes_left", exp_q.size(), 0);
    sb_en = 1'b0;
    apply_vec(tbl[0]);
    bus.cpu_write_enable = 1'b0; bus.cpu_SELECT_obm = 1'b0;

    // Random page with writable low at start (vblank wait when enabled).
    run_xfer(8'($urandom_range(3, 255)), 1'b0, -1, 0, 8, 1'b0, 1'b0);
    cpu_reg_write(1'b0, 1'b1, 8'h00);
    check("irq_later_clear", bus.done_irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
